program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 98 +++++++++
 tb/tb_program_loader.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader: turns a UART byte stream into instruction-memory writes.
// Each received byte is written one cycle later. Bytes are also assembled
// big-endian into words so that a word-aligned HALT instruction ends the
// load. Filling memory without a HALT raises an overflow flag instead.
module program_loader #(
  parameter int                 NB_DATA          = 32,
  parameter int                 NB_BYTE          = 8,
  parameter int                 N_INSTRUCTIONS   = 32,
  parameter int                 N_BYTE_REGISTERS = N_INSTRUCTIONS*4,
  parameter int                 NB_ADDRESS       = $clog2(N_BYTE_REGISTERS),
  parameter logic [NB_DATA-1:0] HALT_INSTRUCTION = 32'hFFFF_FFFF
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [NB_BYTE-1:0]    i_rx_data,
  input  logic                  i_rx_valid,
  output logic [NB_BYTE-1:0]    o_write_data,
  output logic                  o_write_enable,
  output logic                  o_mem_clear,
  output logic [NB_ADDRESS:0]   o_byte_count,
  output logic                  o_load_done,
  output logic                  o_overflow
);

  typedef enum logic [2:0] {IDLE, CLEAR, RECEIVE, DONE, ERROR} state_t;

  localparam logic [NB_ADDRESS:0] FULL = (NB_ADDRESS+1)'(N_BYTE_REGISTERS);

  state_t               state;
  logic [NB_DATA-1:0]   word;
  logic [1:0]           phase;
  logic [NB_DATA-1:0]   next_word;
  logic [NB_ADDRESS:0]  next_count;

  // Word as it would look once the current byte is shifted in (first byte ends up in MSBs).
  assign next_word  = {word[NB_DATA-NB_BYTE-1:0], i_rx_data};
  // Count saturates at memory depth.
  assign next_count = (o_byte_count == FULL) ? o_byte_count : o_byte_count + 1'b1;

  // Load sequencer: all outputs are registered and strobes default low each cycle.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state          <= IDLE;
      word           <= '0;
      phase          <= '0;
      o_write_data   <= '0;
      o_write_enable <= 1'b0;
      o_mem_clear    <= 1'b0;
      o_byte_count   <= '0;
      o_load_done    <= 1'b0;
      o_overflow     <= 1'b0;
    end else begin
      o_write_enable <= 1'b0;
      o_mem_clear    <= 1'b0;
      case (state)
        IDLE: ;
        CLEAR: begin
          o_byte_count <= '0;
          word         <= '0;
          phase        <= '0;
          state        <= RECEIVE;
        end
        RECEIVE: begin
          if (i_rx_valid) begin
            o_write_data   <= i_rx_data;
            o_write_enable <= 1'b1;
            o_byte_count   <= next_count;
            word           <= next_word;
            phase          <= phase + 2'd1;
            // HALT wins when the final word both fills memory and matches.
            if (phase == 2'd3 && next_word == HALT_INSTRUCTION)
              state <= DONE;
            else if (next_count == FULL)
              state <= ERROR;
          end
        end
        // Flags rise one cycle after the last write and hold until restarted.
        DONE:    o_load_done <= 1'b1;
        ERROR:   o_overflow  <= 1'b1;
        default: state <= IDLE;
      endcase
      // A start pulse from any settled state (including mid-load) restarts;
      // it overrides anything above, so a coincident rx strobe is discarded.
      if (i_start && state != CLEAR) begin
        state          <= CLEAR;
        o_mem_clear    <= 1'b1;
        o_write_enable <= 1'b0;
        o_byte_count   <= '0;
        word           <= '0;
        phase          <= '0;
        o_load_done    <= 1'b0;
        o_overflow     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed scenarios plus randomized loads, all
// checked against a transaction-level model of which bytes must be written.
module tb_program_loader;
  localparam int N_BYTES = 128;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = '0;
  logic [7:0] write_data;
  logic       write_enable;
  logic       mem_clear;
  logic [7:0] byte_count;
  logic       load_done;
  logic       overflow;

  program_loader dut (
    .i_clock(clock), .i_reset(reset), .i_start(start),
    .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_write_data(write_data), .o_write_enable(write_enable),
    .o_mem_clear(mem_clear), .o_byte_count(byte_count),
    .o_load_done(load_done), .o_overflow(overflow)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [7:0] sent[$];
  int         sent_cyc[$];
  logic [7:0] got[$];
  int         got_cyc[$];
  int         clr_cnt;
  int         done_cyc;
  int         ovf_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and record what the DUT shows just after the edge.
  task automatic tick();
    @(posedge clock); #1; cyc++;
    if (write_enable === 1'b1) begin got.push_back(write_data); got_cyc.push_back(cyc); end
    if (mem_clear === 1'b1) clr_cnt++;
    if (load_done === 1'b1 && done_cyc < 0) done_cyc = cyc;
    if (overflow === 1'b1 && ovf_cyc < 0) ovf_cyc = cyc;
  endtask

  task automatic clear_rec();
    sent.delete(); sent_cyc.delete(); got.delete(); got_cyc.delete();
    clr_cnt = 0; done_cyc = -1; ovf_cyc = -1;
  endtask

  // Start pulse (optionally with a coincident rx strobe), then the CLEAR cycle.
  task automatic start_load(input bit with_rx);
    clear_rec();
    start = 1'b1; rx_valid = with_rx; rx_data = 8'hA5;
    tick();
    start = 1'b0; rx_valid = 1'b0;
    tick();
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    rx_valid = 1'b1; rx_data = b;
    sent.push_back(b); sent_cyc.push_back(cyc);
    tick();
    rx_valid = 1'b0; rx_data = 8'($urandom);
    repeat (gap) tick();
  endtask

  // Reference: bytes are written in order until a group-of-4-aligned HALT
  // word (inclusive) or until memory is full, whichever comes first.
  task automatic model(output int n, output bit d, output bit o);
    logic [31:0] w;
    w = '0; n = 0; d = 1'b0; o = 1'b0;
    for (int i = 0; i < sent.size(); i++) begin
      w = {w[23:0], sent[i]};
      n++;
      if (i % 4 == 3 && w == HALT) begin d = 1'b1; break; end
      if (n == N_BYTES) begin o = 1'b1; break; end
    end
  endtask

  task automatic check_load(input string tag);
    int n; bit d; bit o; int m;
    repeat (3) tick();
    model(n, d, o);
    check({tag, ".clear"}, clr_cnt, 1);
    check({tag, ".nwrites"}, got.size(), n);
    m = (got.size() < n) ? got.size() : n;
    for (int i = 0; i < m; i++) begin
      check({tag, ".data"}, got[i], sent[i]);
      check({tag, ".lat"}, got_cyc[i], sent_cyc[i] + 1);
    end
    check({tag, ".count"}, byte_count, n);
    check({tag, ".done"}, load_done, d);
    check({tag, ".ovf"}, overflow, o);
    if (d && m > 0) check({tag, ".done_t"}, done_cyc, got_cyc[m-1] + 1);
    if (o && m > 0) check({tag, ".ovf_t"}, ovf_cyc, got_cyc[m-1] + 1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".we"}, write_enable, 0);
    check({tag, ".wd"}, write_data, 0);
    check({tag, ".clr"}, mem_clear, 0);
    check({tag, ".cnt"}, byte_count, 0);
    check({tag, ".done"}, load_done, 0);
    check({tag, ".ovf"}, overflow, 0);
  endtask

  initial begin
    logic [7:0] pat[$];
    int nw;
    clear_rec();
    // Reset state, and bytes in IDLE must not write.
    repeat (2) tick();
    check_zero("reset");
    reset = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) send(8'(i + 1), 0);
    tick();
    check("idle_nowrite", got.size(), 0);
    check("idle_cnt", byte_count, 0);

    // Basic load ending in HALT.
    start_load(1'b0);
    pat = '{8'h20, 8'h01, 8'h00, 8'h05, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    foreach (pat[i]) send(pat[i], 1);
    check_load("basic");

    // Restart from DONE: flags drop, counting restarts.
    start_load(1'b0);
    check("restart_done_clr", load_done, 0);
    for (int i = 0; i < 4; i++) send(8'h10 + 8'(i), 0);
    check_load("restart");

    // Back-to-back strobes.
    start_load(1'b0);
    for (int i = 0; i < 8; i++) send(8'h30 + 8'(i), 0);
    check_load("b2b");

    // FF run straddling a word boundary is not a HALT.
    start_load(1'b0);
    pat = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};
    foreach (pat[i]) send(pat[i], 0);
    check_load("straddle");

    // Overflow: 132 non-HALT bytes.
    start_load(1'b0);
    for (int i = 0; i < 132; i++) send(8'($urandom_range(0, 254)), $urandom_range(0, 1));
    check_load("overflow");
    start_load(1'b0);
    check("ovf_restart_flag", overflow, 0);

    // HALT as the word that fills memory: done wins over overflow.
    for (int i = 0; i < 124; i++) send(8'($urandom_range(0, 254)), 0);
    for (int i = 0; i < 4; i++) send(8'hFF, 0);
    for (int i = 0; i < 4; i++) send(8'h55, 0);
    check_load("halt_full");

    // Abort mid-load with a coincident strobe, which is discarded.
    start_load(1'b0);
    for (int i = 0; i < 5; i++) send(8'h40 + 8'(i), 0);
    start_load(1'b1);
    for (int i = 0; i < 4; i++) send(8'h60 + 8'(i), 1);
    check_load("abort");

    // Asynchronous reset mid-load, then a fresh load.
    start_load(1'b0);
    for (int i = 0; i < 6; i++) send(8'h70 + 8'(i), 0);
    #2 reset = 1'b1;
    #1 check_zero("midreset");
    #2 reset = 1'b0;
    tick();
    clear_rec();
    send(8'h99, 0);
    tick();
    check("postreset_nowrite", got.size(), 0);
    start_load(1'b0);
    for (int i = 0; i < 8; i++) send(8'h80 + 8'(i), 0);
    check_load("fresh");

    // Randomized loads mixing HALT words, stray FFs and idle gaps.
    for (int t = 0; t < 8; t++) begin
      start_load(1'b0);
      nw = $urandom_range(3, 36);
      for (int w = 0; w < nw; w++) begin
        if ($urandom_range(0, 5) == 0)
          for (int b = 0; b < 4; b++) send(8'hFF, $urandom_range(0, 2));
        else
          for (int b = 0; b < 4; b++)
            send(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom), $urandom_range(0, 2));
      end
      check_load("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
